// File: rtl/lab_pkg.sv
// Shared constants for the lab arithmetic blocks: FSM state encodings and default width.
package lab_pkg;

    localparam int LAB_WIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } sub_state_t;

endpackage

// File: rtl/serial_sub_bitsub.sv
// One-bit full subtractor cell: D = A - B - Bin, with borrow-out.
module bitsub (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Difference and borrow are pure functions of the three input bits.
    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: Dout = Ain - Bin - Bi, one bit per clock, LSB first,
// with a start/busy/done handshake. Results are held until the next done.
module serial_sub
    import lab_pkg::*;
#(
    parameter int WIDTH = LAB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Dout,
    output logic             Bo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic             d_bit;
    logic             br_next;

    bitsub u_bitsub (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Bin  (br),
        .D    (d_bit),
        .Bout (br_next)
    );

    // FSM, serial datapath and registered handshake/result outputs.
    // The DONE state is a one-cycle hand-off where the finished result and
    // borrow are copied to the output registers; done is visible the cycle
    // after, when the FSM is already back in IDLE and can accept a new start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Dout   <= '0;
            Bo     <= 1'b0;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= Ain;
                        b_sr  <= Bin;
                        br    <= Bi;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Dout  <= res_sr;
                    Bo    <= br;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=4): handshake timing, borrow and
// wrap-around cases, ignored starts, reset abort, back-to-back and full sweep.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] Ain;
    logic [3:0] Bin;
    logic       Bi;
    logic       busy;
    logic       done;
    logic [3:0] Dout;
    logic       Bo;

    int checks   = 0;
    int failures = 0;

    serial_sub #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Ain   (Ain),
        .Bin   (Bin),
        .Bi    (Bi),
        .busy  (busy),
        .done  (done),
        .Dout  (Dout),
        .Bo    (Bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, busy span, hold stability and result.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          input logic [3:0] ed, input logic eb, input string tag);
        int         cyc;
        int         nbusy;
        logic [3:0] prev;
        bit         moved;
        prev  = Dout;
        moved = 0;
        nbusy = 0;
        Ain = a; Bin = b; Bi = bi; start = 1'b1;
        tick();
        start = 1'b0;
        Ain = 4'($urandom); Bin = 4'($urandom); Bi = 1'($urandom);
        cyc = 1;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if (Dout !== prev) moved = 1;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 6);
        chk({tag, "_busycyc"}, nbusy, 5);
        chk({tag, "_stable"}, moved, 0);
        chk({tag, "_dout"}, Dout, ed);
        chk({tag, "_bo"}, Bo, eb);
    endtask

    initial begin
        int         ndone;
        int         cyc;
        logic [4:0] r;
        logic [3:0] q_a [3];
        logic [3:0] q_b [3];
        logic [3:0] q_d [3];
        logic       q_o [3];

        rst = 1'b1; start = 1'b0; Ain = '0; Bin = '0; Bi = 1'b0;
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", Dout, 0);
        chk("rst_bo", Bo, 0);
        rst = 1'b0;
        tick();

        run_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "9m3");
        chk("done_pulse_busy", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
        run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "3m9");
        run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "0m0m1");
        run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "FmFm1");
        tick();

        // Start while busy must be ignored: one done, at the original latency.
        Ain = 4'd9; Bin = 4'd3; Bi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        Ain = 4'd7; Bin = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3; ndone = 0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        chk("busy_start_latency", cyc, 6);
        chk("busy_start_dout", Dout, 6);
        chk("busy_start_bo", Bo, 0);
        for (int i = 0; i < 10; i++) begin tick(); if (done) ndone++; end
        chk("busy_start_extra_done", ndone, 0);
        run_op(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, "7m1");

        // Reset in the second RUN cycle aborts with no done pulse.
        Ain = 4'd5; Bin = 4'd2; Bi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dout", Dout, 0);
        chk("abort_bo", Bo, 0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (done) ndone++; end
        chk("abort_no_done", ndone, 0);

        // Back-to-back with start held high: new operands presented at each done.
        q_a[0] = 4'd12; q_b[0] = 4'd5;  q_d[0] = 4'd7;  q_o[0] = 1'b0;
        q_a[1] = 4'd2;  q_b[1] = 4'd4;  q_d[1] = 4'hE;  q_o[1] = 1'b1;
        q_a[2] = 4'd8;  q_b[2] = 4'd8;  q_d[2] = 4'd0;  q_o[2] = 1'b0;
        Ain = q_a[0]; Bin = q_b[0]; Bi = 1'b0; start = 1'b1;
        ndone = 0; cyc = 0;
        for (int i = 0; i < 40 && ndone < 3; i++) begin
            tick();
            cyc++;
            if (done) begin
                chk("b2b_gap", cyc, 6);
                chk("b2b_dout", Dout, q_d[ndone]);
                chk("b2b_bo", Bo, q_o[ndone]);
                ndone++;
                cyc = 0;
                if (ndone < 3) begin
                    Ain = q_a[ndone]; Bin = q_b[ndone];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 3);
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_idle", busy, 0);

        // Full sweep against the 5-bit reference difference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    r = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(c);
                    run_op(4'(a), 4'(b), 1'(c), r[3:0], r[4], "sweep");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
